// File: rtl/gba_loader_pkg.sv
// Shared types and constants for the ROM download bridge.
// Holds the loader FSM states, the default header check values and the lane-mask helper.
package gba_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWrite,
        StFlush,
        StHold
    } loader_state_t;

    localparam int unsigned HdrFixedOfs = 'hB2;
    localparam logic [7:0]  HdrFixedVal = 8'h96;
    localparam int unsigned MaxBeW      = 4;

    // Byte-enable bits covered by beat number `beat` when each beat is `beat_bytes` wide.
    function automatic logic [MaxBeW-1:0] lane_mask(input int unsigned beat,
                                                    input int unsigned beat_bytes);
        return MaxBeW'(((1 << beat_bytes) - 1) << (beat * beat_bytes));
    endfunction

endpackage

// File: rtl/gba_loader_packer.sv
// Gathers IN_DW-bit beats into one OUT_DW-bit word, little-endian, with a per-byte valid mask.
// Unfilled lanes always read as zero so a partial word can be written as-is.
module gba_loader_packer
    import gba_loader_pkg::*;
#(
    parameter int unsigned IN_DW  = 8,
    parameter int unsigned OUT_DW = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                push_i,
    input  logic [IN_DW-1:0]    data_i,
    output logic [OUT_DW-1:0]   data_o,
    output logic [OUT_DW/8-1:0] be_o,
    output logic                last_o,
    output logic                empty_o
);
    localparam int unsigned Beats     = OUT_DW / IN_DW;
    localparam int unsigned BeatBytes = IN_DW / 8;
    localparam int unsigned BeW       = OUT_DW / 8;
    localparam int unsigned CntW      = $clog2(Beats + 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [OUT_DW-1:0] data_q, data_d;
    logic [BeW-1:0]    be_q, be_d;

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        be_d   = be_q;
        if (clear_i) begin
            cnt_d  = '0;
            data_d = '0;
            be_d   = '0;
        end else if (push_i) begin
            for (int unsigned k = 0; k < Beats; k++) begin
                if (cnt_q == CntW'(k)) data_d[k*IN_DW +: IN_DW] = data_i;
            end
            be_d  = be_q | BeW'(lane_mask(32'(cnt_q), BeatBytes));
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            data_q <= '0;
            be_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
            be_q   <= be_d;
        end
    end

    assign data_o  = data_q;
    assign be_o    = be_q;
    assign last_o  = (cnt_q == CntW'(Beats - 1));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/gba_rom_loader.sv
// Bridge from the hps_io ioctl download stream to SDRAM word writes, with per-index region bases,
// a cartridge header sanity check and a core reset held until the download has settled.
module gba_rom_loader
    import gba_loader_pkg::*;
#(
    parameter int unsigned IOCTL_DW      = 8,
    parameter int unsigned MEM_DW        = 16,
    parameter int unsigned ADDR_W        = 25,
    parameter int unsigned REGION_SHIFT  = 24,
    parameter int unsigned HDR_FIXED_OFS = HdrFixedOfs,
    parameter logic [7:0]  HDR_FIXED_VAL = HdrFixedVal,
    parameter int unsigned RESET_HOLD    = 255
) (
    input  logic                clk_sys_i,
    input  logic                reset_n_i,
    input  logic                ioctl_download_i,
    input  logic [7:0]          ioctl_index_i,
    input  logic                ioctl_wr_i,
    input  logic [IOCTL_DW-1:0] ioctl_dout_i,
    output logic                ioctl_wait_o,
    output logic                mem_req_o,
    input  logic                mem_ack_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [MEM_DW-1:0]   mem_din_o,
    output logic [MEM_DW/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   rom_bytes_o,
    output logic                hdr_ok_o,
    output logic                overrun_o,
    output logic                core_reset_o
);
    localparam int unsigned BeatBytes = IOCTL_DW / 8;
    localparam int unsigned WordBytes = MEM_DW / 8;
    localparam int unsigned CntW      = REGION_SHIFT + 1;
    localparam int unsigned HoldW     = $clog2(RESET_HOLD + 2);

    loader_state_t     state_q, state_d;
    logic              download_q, download_d;
    logic              region0_q, region0_d;
    logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rom_bytes_q, rom_bytes_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              ioctl_wait_q, ioctl_wait_d;
    logic              hdr_ok_q, hdr_ok_d;
    logic              overrun_q, overrun_d;
    logic              core_reset_q, core_reset_d;

    logic              rise, start, accept, region_full, to_hold, pk_clear, pk_last, pk_empty;
    logic [ADDR_W-1:0] base;

    assign rise        = ioctl_download_i & ~download_q;
    assign start       = rise && (state_q == StIdle || state_q == StHold);
    // The top count bit marks a full region; beats are dropped from then on.
    assign region_full = byte_cnt_q[REGION_SHIFT];
    assign accept      = (state_q == StCollect) && ioctl_download_i && ioctl_wr_i &&
                         !ioctl_wait_q && !region_full;
    assign base        = ADDR_W'(ADDR_W'(ioctl_index_i) << REGION_SHIFT);

    gba_loader_packer #(
        .IN_DW  (IOCTL_DW),
        .OUT_DW (MEM_DW)
    ) u_packer (
        .clk_i   (clk_sys_i),
        .rst_ni  (reset_n_i),
        .clear_i (pk_clear),
        .push_i  (accept),
        .data_i  (ioctl_dout_i),
        .data_o  (mem_din_o),
        .be_o    (mem_be_o),
        .last_o  (pk_last),
        .empty_o (pk_empty)
    );

    always_comb begin
        state_d      = state_q;
        download_d   = ioctl_download_i;
        region0_d    = region0_q;
        byte_cnt_d   = byte_cnt_q;
        addr_d       = addr_q;
        rom_bytes_d  = rom_bytes_q;
        hold_cnt_d   = hold_cnt_q;
        mem_req_d    = mem_req_q;
        ioctl_wait_d = ioctl_wait_q;
        hdr_ok_d     = hdr_ok_q;
        overrun_d    = overrun_q;
        core_reset_d = core_reset_q;
        pk_clear     = 1'b0;
        to_hold      = 1'b0;

        if (ioctl_wr_i && !accept && state_q != StIdle && state_q != StHold) overrun_d = 1'b1;

        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + CntW'(BeatBytes);
                    for (int unsigned j = 0; j < BeatBytes; j++) begin
                        if (region0_q && (byte_cnt_q + CntW'(j) == CntW'(HDR_FIXED_OFS))) begin
                            hdr_ok_d = (ioctl_dout_i[j*8 +: 8] == HDR_FIXED_VAL);
                        end
                    end
                    if (pk_last) begin
                        state_d      = StWrite;
                        mem_req_d    = 1'b1;
                        ioctl_wait_d = 1'b1;
                    end
                end else if (!ioctl_download_i) begin
                    if (!pk_empty) begin
                        state_d      = StFlush;
                        mem_req_d    = 1'b1;
                        ioctl_wait_d = 1'b1;
                    end else begin
                        to_hold = 1'b1;
                    end
                end
            end
            StWrite, StFlush: begin
                if (mem_ack_i) begin
                    mem_req_d    = 1'b0;
                    ioctl_wait_d = 1'b0;
                    addr_d       = addr_q + ADDR_W'(WordBytes);
                    pk_clear     = 1'b1;
                    // A full-word write leaves the packer empty, so no flush can follow it.
                    if (state_q == StFlush || !ioctl_download_i) to_hold = 1'b1;
                    else state_d = StCollect;
                end
            end
            StHold: begin
                if (hold_cnt_q <= HoldW'(1)) begin
                    hold_cnt_d   = '0;
                    core_reset_d = 1'b0;
                    state_d      = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q - HoldW'(1);
                end
            end
            default: ;
        endcase

        if (to_hold) begin
            state_d     = StHold;
            rom_bytes_d = ADDR_W'(byte_cnt_q);
            hold_cnt_d  = HoldW'(RESET_HOLD);
        end

        if (start) begin
            state_d      = StCollect;
            region0_d    = (ioctl_index_i == 8'd0);
            addr_d       = base;
            byte_cnt_d   = '0;
            hdr_ok_d     = 1'b0;
            overrun_d    = 1'b0;
            hold_cnt_d   = HoldW'(RESET_HOLD);
            core_reset_d = 1'b1;
            pk_clear     = 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (!reset_n_i) begin
            state_q      <= StIdle;
            download_q   <= 1'b0;
            region0_q    <= 1'b0;
            byte_cnt_q   <= '0;
            addr_q       <= '0;
            rom_bytes_q  <= '0;
            hold_cnt_q   <= HoldW'(RESET_HOLD);
            mem_req_q    <= 1'b0;
            ioctl_wait_q <= 1'b0;
            hdr_ok_q     <= 1'b0;
            overrun_q    <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            download_q   <= download_d;
            region0_q    <= region0_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_q       <= addr_d;
            rom_bytes_q  <= rom_bytes_d;
            hold_cnt_q   <= hold_cnt_d;
            mem_req_q    <= mem_req_d;
            ioctl_wait_q <= ioctl_wait_d;
            hdr_ok_q     <= hdr_ok_d;
            overrun_q    <= overrun_d;
            core_reset_q <= core_reset_d;
        end
    end

    assign ioctl_wait_o = ioctl_wait_q;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = addr_q;
    assign rom_bytes_o  = rom_bytes_q;
    assign hdr_ok_o     = hdr_ok_q;
    assign overrun_o    = overrun_q;
    assign core_reset_o = core_reset_q;

endmodule
